// File: rtl/add_share_pkg.sv
// Shared types for the adder-sharing scheduler: FSM state encoding and ID width helper.
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_share_arb_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
// Zero latency; produces no grant when nothing is requesting.
module rr_arbiter
  import add_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin scheduler sharing one external adder between NREQ valid/ready requesters.
// Accept -> response valid two cycles later; rsp held until rsp_ready, no accepts while busy.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_sum,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_a     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_b     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Operand regs double as the adder's input pins, so they only move on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            rsp_id <= gnt_idx;
            ptr    <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum[WIDTH-1:0];
          rsp_carry <= add_sum[WIDTH];
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
